// File: rtl/reg_dump.sv
// Register-file dump engine: reads NUM_REGS 32-bit registers in address order and
// streams each one out as four little-endian bytes over a valid/ready byte interface.
module reg_dump #(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  input  logic        byte_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

  state_e      state_q;
  logic [4:0]  reg_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] shreg_q;
  logic        busy_q;
  logic        done_q;
  logic        valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      reg_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= LOAD;
            reg_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          shreg_q    <= rd_data;
          byte_cnt_q <= '0;
          valid_q    <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          // Nothing moves until the downstream accepts the current byte.
          if (byte_ready) begin
            if (byte_cnt_q != 2'd3) begin
              shreg_q    <= {8'h00, shreg_q[31:8]};
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end else if (reg_cnt_q == LAST_REG) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              valid_q   <= 1'b0;
              reg_cnt_q <= reg_cnt_q + 5'd1;
              state_q   <= LOAD;
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_addr    = reg_cnt_q;
  assign byte_valid = valid_q;
  assign byte_data  = shreg_q[7:0];

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of registers dumped (addresses 0..NUM_REGS-1; range 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  dump request, sampled in IDLE only.
REQ-005 SHALL have port busy  output  1  high in any state other than IDLE; register-file writes are to be held off by the integrator while high.
REQ-006 SHALL have port done  output  1  one-cycle pulse on completion of a full dump.
REQ-007 SHALL have port rd_addr  output  5  register-file read address, driven from internal register counter.
REQ-008 SHALL have port rd_data  input  32  register-file read data, combinationally valid in the same cycle as rd_addr.
REQ-009 SHALL have port byte_valid  output  1  byte stream valid.
REQ-010 SHALL have port byte_data  output  8  byte stream payload.
REQ-011 SHALL have port byte_ready  input  1  downstream accept; transfer occurs on a clk edge with byte_valid and byte_ready both high.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, SEND, FIN.
REQ-013 IDLE: start=1 SHALL transition to LOAD next cycle with reg counter=0; start=0 SHALL remain IDLE.
REQ-014 LOAD: SHALL capture rd_data into a 32-bit shift register, clear the byte counter (2 bits), transition to SEND; exactly one cycle.
REQ-015 SEND: byte_valid SHALL be 1 and byte_data SHALL be shift register bits [7:0] (little-endian: byte 0 = bits 7:0 of the register).
REQ-016 SEND with byte_ready=0: byte_valid, byte_data, counters SHALL hold unchanged.
REQ-017 SEND transfer with byte counter<3: shift register SHALL shift right by 8, byte counter increments, stay in SEND.
REQ-018 SEND transfer with byte counter=3 and reg counter<NUM_REGS-1: reg counter SHALL increment, go to LOAD.
REQ-019 SEND transfer with byte counter=3 and reg counter=NUM_REGS-1: SHALL go to FIN; reg counter does not wrap past NUM_REGS-1.
REQ-020 FIN: done SHALL be 1 for exactly that cycle, then IDLE.
REQ-021 byte_valid SHALL be 0 in IDLE, LOAD, FIN.
REQ-022 rd_addr SHALL equal the reg counter in all states.
REQ-023 start SHALL be ignored in LOAD, SEND, FIN; no re-queueing.
REQ-024 start held high continuously SHALL begin a new dump in the IDLE cycle following FIN (one idle cycle between dumps).
REQ-025 One dump SHALL emit exactly 4*NUM_REGS bytes; minimum duration with byte_ready tied 1 = 1 (IDLE) + 5*NUM_REGS + 1 (FIN) cycles from start sample.
REQ-026 Register x0 SHALL be dumped like any other address (value supplied by rd_data).

Reset
REQ-027 rst=0 SHALL immediately, asynchronously force state IDLE, reg counter 0, byte counter 0, shift register 0.
REQ-028 During reset: busy=0, done=0, byte_valid=0, byte_data=0x00, rd_addr=0.
REQ-029 Reset mid-dump SHALL abandon the dump with no done pulse; after release, a new start restarts from register 0.

Verification
REQ-030 Regfile model x[i]=0x11223300+i, NUM_REGS=32, byte_ready=1, start pulse -> 128 bytes, first four 0x00,0x33,0x22,0x11, last four 0x1F,0x33,0x22,0x11; done pulses once, at cycle 1+160+1 after start.
REQ-031 Random byte_ready stalls -> identical byte sequence; byte_data stable whenever byte_valid=1 and byte_ready=0.
REQ-032 start pulsed repeatedly during busy -> exactly one dump, one done pulse.
REQ-033 rst asserted after 50th byte -> byte_valid drops same cycle without clock, no done; restart yields full 128-byte dump starting 0x00,0x33.
REQ-034 NUM_REGS=1, x0=0xDEADBEEF -> bytes 0xEF,0xBE,0xAD,0xDE, then done; rd_addr stays 0.
REQ-035 start held high -> back-to-back dumps separated by exactly one IDLE cycle with byte_valid=0.
